// File: rtl/fifo_rd_drain.sv
`timescale 1ns / 1ps
// fifo_rd_drain: read-side consumer of the dual-clock FIFO, rd_clk domain only.
//
// Pops words from the FIFO and presents them on a valid/ready stream. A 2-entry
// output buffer hides the FIFO's 1-cycle read latency so a word can be delivered
// every cycle. Also keeps a delivered-word counter and a sticky underflow flag.
//
// Optional feature: define FIFO_RD_CNT_SAT_EN to make rd_count saturate at
// 2^CNT_W-1 instead of wrapping.
//
// Ports:
//   rd_clk        read-domain clock (posedge)
//   res           async active-low reset
//   empty         FIFO empty flag
//   underflow     FIFO underflow flag
//   rdata         FIFO read data, valid the cycle after rd_en
//   rd_en         FIFO pop request (combinational)
//   enable        1 = fetch from FIFO, 0 = stop fetching and drain
//   m_valid       output word valid
//   m_data        output word
//   m_ready       downstream ready
//   rd_count      words delivered downstream
//   err_underflow sticky underflow error
//   clr_err       clears err_underflow (set wins)
//   idle          1 while in the idle state
module fifo_rd_drain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             res,
    input  logic             empty,
    input  logic             underflow,
    input  logic [WIDTH-1:0] rdata,
    output logic             rd_en,
    input  logic             enable,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic             err_underflow,
    input  logic             clr_err,
    output logic             idle
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [WIDTH-1:0] buf0_q, buf0_d;  // head
    logic [WIDTH-1:0] buf1_q, buf1_d;  // tail when occ_q == 2
    logic [CNT_W-1:0] cnt_d;
    logic             pop;
    logic [1:0]       level;

    assign pop = m_valid && m_ready;

    // Entries that will be held after this cycle's capture and pop. pop implies
    // occ_q >= 1, so this never goes negative, and it never exceeds 2.
    assign level = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    assign rd_en = (state_q == StRun) && enable && !empty && (level < 2'd2);

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = rdata;
                end else begin
                    buf1_d = rdata;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Head leaves while the new word joins the tail.
                if (occ_q == 2'd1) begin
                    buf0_d = rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rdata;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = rd_count;
`ifdef FIFO_RD_CNT_SAT_EN
        if (pop && (rd_count != {CNT_W{1'b1}})) begin
            cnt_d = rd_count + CNT_W'(1);
        end
`else
        if (pop) begin
            cnt_d = rd_count + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge rd_clk or negedge res) begin
        if (!res) begin
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            rd_count      <= '0;
            err_underflow <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            m_valid    <= (occ_d != 2'd0);
            m_data     <= buf0_d;
            rd_count   <= cnt_d;
            if (underflow) begin
                err_underflow <= 1'b1;
            end else if (clr_err) begin
                err_underflow <= 1'b0;
            end
        end
    end

    // Control FSM; idle is registered alongside the state it reflects.
    always_ff @(posedge rd_clk or negedge res) begin
        if (!res) begin
            state_q <= StIdle;
            idle    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StRun;
                        idle    <= 1'b0;
                    end
                end
                StRun: begin
                    if (!enable) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // rd_en is low here, so nothing new is in flight next cycle;
                    // leave once the buffer is empty after this cycle's pop.
                    if (enable) begin
                        state_q <= StRun;
                    end else if (occ_d == 2'd0) begin
                        state_q <= StIdle;
                        idle    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    idle    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
`timescale 1ns / 1ps
module tb_fifo_rd_drain;

    localparam int W = 8;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic         res;
    logic         underflow, clr_err, enable, m_ready;
    logic [W-1:0] rdata;
    logic         empty, rd_en, m_valid, idle, err_underflow;
    logic [W-1:0] m_data;
    logic [15:0]  rd_count;

    // Second instance with a narrow counter for the wrap/saturate check.
    logic         empty2, rd_en2, m_valid2, idle2, err2;
    logic [W-1:0] m_data2;
    logic [3:0]   rd_count2;
    int           rem2;

    logic [W-1:0] fifo_mem [0:255];
    int           wr_ptr, rd_ptr;

    assign empty  = (rd_ptr == wr_ptr);
    assign empty2 = (rem2 == 0);

    fifo_rd_drain #(.WIDTH(W), .CNT_W(16)) dut (
        .rd_clk(rd_clk), .res(res), .empty(empty), .underflow(underflow), .rdata(rdata),
        .rd_en(rd_en), .enable(enable), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .rd_count(rd_count), .err_underflow(err_underflow),
        .clr_err(clr_err), .idle(idle)
    );

    fifo_rd_drain #(.WIDTH(W), .CNT_W(4)) dut2 (
        .rd_clk(rd_clk), .res(res), .empty(empty2), .underflow(1'b0), .rdata(8'h5A),
        .rd_en(rd_en2), .enable(1'b1), .m_valid(m_valid2), .m_data(m_data2),
        .m_ready(1'b1), .rd_count(rd_count2), .err_underflow(err2),
        .clr_err(1'b0), .idle(idle2)
    );

    // Model: exp_q holds every word taken from the FIFO and not yet delivered,
    // including the one in flight; mode 0 idle, 1 run, 2 drain.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] log_q[$];
    int           pop_cyc_q[$];
    int           mode, cnt_model, pops2, cyc, first_rd_en_cyc;
    logic         err_model, inflight_m;
    logic         s_rd_en, s_pop, s_en, s_und, s_clr, s_valid, s_rd_en2, s_pop2;
    int           vecs, miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        inflight_m = 1'b0;
        mode       = 0;
        cnt_model  = 0;
        err_model  = 1'b0;
        rd_ptr     = wr_ptr;
        rem2       = 0;
    endtask

    // One clock cycle: check at the negedge, advance model just after posedge.
    task automatic step();
        int   buffered;
        logic ev;
        @(negedge rd_clk);
        s_rd_en  = rd_en;
        s_pop    = m_valid && m_ready;
        s_en     = enable;
        s_und    = underflow;
        s_clr    = clr_err;
        s_valid  = m_valid;
        s_rd_en2 = rd_en2;
        s_pop2   = m_valid2;
        if (res) begin
            buffered = exp_q.size() - (inflight_m ? 1 : 0);
            chk("m_valid", m_valid, buffered > 0);
            if (buffered > 0) chk("m_data", m_data, exp_q[0]);
            chk("rd_count", rd_count, cnt_model % 65536);
            chk("err_underflow", err_underflow, err_model);
            chk("idle", idle, mode == 0);
            ev = (mode == 1) && enable && !empty && ((exp_q.size() - (s_pop ? 1 : 0)) < 2);
            chk("rd_en", rd_en, ev);
            chk("occupancy_le_2", exp_q.size() <= 2, 1);
            if (rd_en && first_rd_en_cyc < 0) first_rd_en_cyc = cyc;
        end
        @(posedge rd_clk);
        #1;
        if (res) begin
            if (s_pop && exp_q.size() > 0) begin
                log_q.push_back(exp_q.pop_front());
                pop_cyc_q.push_back(cyc);
                cnt_model++;
            end
            inflight_m = s_rd_en;
            if (s_rd_en) begin
                rdata = fifo_mem[rd_ptr[7:0]];
                rd_ptr++;
                exp_q.push_back(rdata);
            end
            if (s_und) err_model = 1'b1;
            else if (s_clr) err_model = 1'b0;
            case (mode)
                0: if (s_en) mode = 1;
                1: if (!s_en) mode = 2;
                2: if (s_en) mode = 1; else if (exp_q.size() == 0) mode = 0;
                default: mode = 0;
            endcase
            if (s_rd_en2 && rem2 > 0) rem2--;
            if (s_pop2) pops2++;
        end
        cyc++;
    endtask

    task automatic push_words(input logic [W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = first + W'(i);
            wr_ptr++;
        end
    endtask

    initial begin
        int n0;
        vecs = 0; miss = 0; cyc = 0; first_rd_en_cyc = -1; pops2 = 0;
        res = 1'b0; enable = 1'b0; m_ready = 1'b0; underflow = 1'b0; clr_err = 1'b0;
        rdata = '0; wr_ptr = 0; rd_ptr = 0;
        reset_model();

        // Reset values
        repeat (2) @(posedge rd_clk);
        #1;
        chk("reset rd_en", rd_en, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset rd_count", rd_count, 0);
        chk("reset err", err_underflow, 0);
        chk("reset idle", idle, 1);
        res = 1'b1;

        // Streaming 0x01..0x10 with m_ready=1; dut2 gets 17 words in parallel.
        push_words(8'h01, 16);
        rem2 = 17;
        enable = 1'b1;
        m_ready = 1'b1;
        repeat (30) step();
        chk("stream count", log_q.size(), 16);
        chk("stream first word", log_q[0], 8'h01);
        chk("stream last word", log_q[15], 8'h10);
        chk("stream consecutive", pop_cyc_q[15] - pop_cyc_q[0], 15);
        chk("stream latency", pop_cyc_q[0] - first_rd_en_cyc, 2);
        chk("stream rd_count", rd_count, 16);
        chk("stream rd_en empty", rd_en, 0);
        chk("cnt4 pops", pops2, 17);
`ifdef FIFO_RD_CNT_SAT_EN
        chk("cnt4 rd_count", rd_count2, 15);
`else
        chk("cnt4 rd_count", rd_count2, 1);
`endif

        // Backpressure: m_ready 1,0,0,1 repeating
        log_q.delete();
        push_words(8'h11, 16);
        for (int k = 0; k < 80; k++) begin
            m_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        chk("bp count", log_q.size(), 16);
        chk("bp first word", log_q[0], 8'h11);
        chk("bp last word", log_q[15], 8'h20);
        chk("bp rd_count", rd_count, 32);

        // Drain: drop enable right after a cycle with rd_en=1 and occ=1
        log_q.delete();
        m_ready = 1'b1;
        push_words(8'h31, 6);
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_rd_en && s_valid) break;
        end
        chk("drain setup", s_rd_en && s_valid, 1);
        enable = 1'b0;
        n0 = log_q.size();
        step();
        chk("drain rd_en low", s_rd_en, 0);
        for (int k = 0; k < 6; k++) begin
            if (idle) break;
            step();
        end
        chk("drain words", log_q.size() - n0, 2);
        chk("drain idle", idle, 1);

        // Sticky error
        underflow = 1'b1;
        step();
        underflow = 1'b0;
        chk("err set", err_underflow, 1);
        repeat (3) step();
        chk("err sticky", err_underflow, 1);
        underflow = 1'b1;
        clr_err = 1'b1;
        step();
        underflow = 1'b0;
        clr_err = 1'b0;
        chk("err set beats clr", err_underflow, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("err clr", err_underflow, 0);

        // Reset mid-stream with two words buffered
        push_words(8'h41, 4);
        enable = 1'b1;
        m_ready = 1'b0;
        underflow = 1'b1;
        step();
        underflow = 1'b0;
        repeat (5) step();
        chk("pre-reset m_valid", m_valid, 1);
        chk("pre-reset buffered", exp_q.size(), 2);
        #2;
        res = 1'b0;
        #1;
        chk("midreset m_valid", m_valid, 0);
        chk("midreset rd_en", rd_en, 0);
        chk("midreset rd_count", rd_count, 0);
        chk("midreset err", err_underflow, 0);
        chk("midreset idle", idle, 1);
        reset_model();
        enable = 1'b0;
        repeat (2) step();
        res = 1'b1;
        m_ready = 1'b1;
        repeat (5) step();
        chk("post-reset m_valid", m_valid, 0);
        chk("post-reset rd_en", rd_en, 0);
        chk("post-reset rd_count", rd_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer of the dual-clock FIFO; lives entirely in the read clock domain.
- Pops words from the FIFO (rd_en/rdata/empty/underflow) and presents them on a valid/ready stream to the next stage.
- Hides the FIFO's 1-cycle read latency with a 2-entry output buffer, so throughput is one word per cycle.
- Also provides a delivered-word counter and a sticky underflow error flag.

Parameters:
- WIDTH, 8, data word width; must match the FIFO data width.
- CNT_W, 16, width of delivered-word counter rd_count.

Ports:
- rd_clk  in  1  read-domain clock; all logic on posedge.
- res  in  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert supplied externally.
- empty  in  1  FIFO empty flag.
- underflow  in  1  FIFO underflow flag.
- rdata  in  WIDTH  FIFO read data; valid the cycle after rd_en is sampled high.
- rd_en  out  1  FIFO pop request.
- enable  in  1  1 = fetch from FIFO; 0 = stop fetching and drain.
- m_valid  out  1  output word valid.
- m_data  out  WIDTH  output word.
- m_ready  in  1  downstream accepts word when m_valid && m_ready.
- rd_count  out  CNT_W  number of words delivered downstream.
- err_underflow  out  1  sticky underflow error.
- clr_err  in  1  clears err_underflow.
- idle  out  1  1 when in IDLE state.

Behaviour:
- Reset values (res=0):
  - rd_en=0, m_valid=0, m_data=0, rd_count=0, err_underflow=0, idle=1.
  - Buffer occupancy=0, inflight_q=0, state=IDLE.
- All outputs are registered except rd_en, which is combinational from registered state plus empty/enable/m_ready.
- Definitions:
  - pop = m_valid && m_ready.
  - inflight_q = rd_en registered; it marks that rdata arrives this cycle.
  - occ = 0..2 entries held in the FIFO-ordered output buffer.
- rd_en = (state==RUN) && enable && !empty && (occ + inflight_q - pop) < 2.
  - The buffer therefore can never overflow.
  - Never assert rd_en while empty==1.
- Buffer update:
  - When inflight_q=1, rdata is written at the tail.
  - On pop, the head is removed.
  - Simultaneous write and pop: occ unchanged, ordering preserved.
- m_valid = (occ != 0); m_data = head entry.
  - Once m_valid=1 it holds, with m_data stable, until pop.
- Latency:
  - Word popped with rd_en in cycle N is captured at the end of N+1 and appears on m_data in cycle N+2.
  - With m_ready=1 and FIFO non-empty, steady-state rate is 1 word/cycle.
- rd_count increments by 1 on every pop; wraps to 0 after 2^CNT_W-1.
- err_underflow:
  - Set on any cycle with underflow==1.
  - Cleared by clr_err=1.
  - Set has priority over clear in the same cycle.
- State machine:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → IDLE when occ==0 && inflight_q==0 && !(pending pop changing that).
  - DRAIN → RUN when enable=1 again.
  - In DRAIN: rd_en=0; data already in flight is still captured and delivered.
  - idle=1 only in IDLE.
- Backpressure: m_ready=0 for any duration loses and duplicates nothing. At most 2 words are buffered, then rd_en stays low.
- Reset mid-operation:
  - Buffer contents and any in-flight word are discarded; outputs return to reset values immediately.
  - The FIFO is expected to be reset by the same res.

Optional Feature:
- Macro FIFO_RD_CNT_SAT_EN.
- Defined: rd_count saturates at 2^CNT_W-1 and holds there on further pops until reset.
- Not defined: rd_count wraps modulo 2^CNT_W as above.
- No other behaviour changes.

Test Plan:
- Reset:
  - Stimulus: res=0 mid-stream with occ=2.
  - Response: same cycle m_valid=0, rd_en=0, rd_count=0, err_underflow=0, idle=1. After release with enable=0, outputs stay quiet.
- Streaming:
  - Stimulus: FIFO preloaded with 0x01..0x10, enable=1, m_ready=1.
  - Response: m_data delivers 0x01..0x10 in order on 16 consecutive cycles, first word 2 cycles after first rd_en. rd_count=16, then rd_en=0 once empty=1.
- Backpressure:
  - Stimulus: same stream with m_ready toggled 1,0,0,1 repeating.
  - Response: no loss or duplication; occ never >2; rd_en low whenever occ+inflight_q-pop=2.
- Drain:
  - Stimulus: enable dropped in the cycle rd_en=1 with occ=1.
  - Response: rd_en=0 next cycle; 2 remaining words are still delivered; idle=1 after the last pop.
- Error:
  - Stimulus: underflow pulsed 1 cycle → err_underflow=1 and stays.
  - Stimulus: clr_err=1 together with underflow=1 → stays 1.
  - Stimulus: clr_err=1 alone → 0.
- Counter:
  - Stimulus: CNT_W=4, deliver 17 words.
  - Response: rd_count=1 with macro undefined; 15 with FIFO_RD_CNT_SAT_EN defined.
